// File: rtl/mc_ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle RV32I control FSM.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HALT       = 3'd0,
        ST_FETCH_REQ  = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_DECODE     = 3'd3,
        ST_EXECUTE    = 3'd4,
        ST_MEM_REQ    = 3'd5,
        ST_MEM_WAIT   = 3'd6,
        ST_WRITEBACK  = 3'd7
    } ctrl_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        PC_SEL_PLUS4   = 2'd0,
        PC_SEL_PC_IMM  = 2'd1,
        PC_SEL_RS1_IMM = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_LOAD = 2'd1,
        WB_SEL_PC4  = 2'd2
    } wb_sel_e;

    // SYSTEM is only legal as ECALL/EBREAK (funct3 = 000)
    function automatic logic isLegalOpcode(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
            OPC_SYSTEM: return (f3 == 3'b000);
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_core_ctrl_perf_cnt.sv
// Free-running 64-bit cycle and retired-instruction counters for mc_core_ctrl.
// Instantiated only when CTRL_PERF_CNT_EN is defined.
module mc_perf_cnt (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        cycle_en_i,
    input  logic        instret_en_i,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] instret_cnt_o
);

    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_en_i   ? cycle_q + 64'd1   : cycle_q;
        instret_d = instret_en_i ? instret_q + 64'd1 : instret_q;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;

endmodule

// File: rtl/mc_core_ctrl.sv
// Multi-cycle (non-pipelined) RV32I control FSM: fetch, decode, execute, memory, writeback.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module mc_core_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned RESET_HALT = 0
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        alu_src_b,
    output logic [1:0]  wb_sel,
    output logic        rf_we,
    output logic        illegal,
`ifdef CTRL_PERF_CNT_EN
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt,
`endif
    output logic        halted
);

    localparam ctrl_state_e RESET_STATE = (RESET_HALT != 0) ? ST_HALT : ST_FETCH_REQ;

    ctrl_state_e state_q, state_d;
    logic        illegal_q, illegal_d;
    pc_sel_e     pcSel;
    wb_sel_e     wbSel;

    logic isBranch, isLoad, isStore, isOp, isJal, isJalr, isEnvCall;

    always_comb begin
        isBranch  = (opcode == OPC_BRANCH);
        isLoad    = (opcode == OPC_LOAD);
        isStore   = (opcode == OPC_STORE);
        isOp      = (opcode == OPC_OP);
        isJal     = (opcode == OPC_JAL);
        isJalr    = (opcode == OPC_JALR);
        isEnvCall = (opcode == OPC_SYSTEM) && (funct3 == 3'b000);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= RESET_STATE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_HALT:       if (start) state_d = ST_FETCH_REQ;
            ST_FETCH_REQ:  if (imem_gnt) state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: if (imem_rvalid) state_d = ST_DECODE;
            ST_DECODE: begin
                if (isEnvCall) begin
                    state_d = ST_HALT;
                end else if (isLegalOpcode(opcode, funct3)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_EXECUTE: begin
                if (isBranch)               state_d = ST_FETCH_REQ;
                else if (isLoad || isStore) state_d = ST_MEM_REQ;
                else                        state_d = ST_WRITEBACK;
            end
            ST_MEM_REQ:    if (dmem_gnt) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (dmem_rvalid) state_d = isLoad ? ST_WRITEBACK : ST_FETCH_REQ;
            end
            ST_WRITEBACK:  state_d = ST_FETCH_REQ;
            default:       state_d = ST_HALT;
        endcase
    end

    // Outputs are forced low while reset is asserted, even though the reset state may request a fetch
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        alu_src_b = 1'b0;
        rf_we     = 1'b0;
        halted    = 1'b0;
        pcSel     = PC_SEL_PLUS4;
        wbSel     = WB_SEL_ALU;
        if (arst_n) begin
            case (state_q)
                ST_HALT:       halted   = 1'b1;
                ST_FETCH_REQ:  imem_req = 1'b1;
                ST_FETCH_WAIT: ir_en    = imem_rvalid;
                ST_EXECUTE: begin
                    alu_src_b = !(isOp || isBranch);
                    if (isBranch) begin
                        pc_en = 1'b1;
                        pcSel = branch_taken ? PC_SEL_PC_IMM : PC_SEL_PLUS4;
                    end
                end
                ST_MEM_REQ: begin
                    dmem_req = 1'b1;
                    dmem_we  = isStore;
                end
                ST_MEM_WAIT:   pc_en = dmem_rvalid && !isLoad;
                ST_WRITEBACK: begin
                    rf_we = 1'b1;
                    pc_en = 1'b1;
                    if (isJal)       pcSel = PC_SEL_PC_IMM;
                    else if (isJalr) pcSel = PC_SEL_RS1_IMM;
                    if (isJal || isJalr) wbSel = WB_SEL_PC4;
                    else if (isLoad)     wbSel = WB_SEL_LOAD;
                end
                default: ;
            endcase
        end
    end

    assign pc_sel  = pcSel;
    assign wb_sel  = wbSel;
    assign illegal = illegal_q;

`ifdef CTRL_PERF_CNT_EN
    mc_perf_cnt u_perf_cnt (
        .clk          (clk),
        .arst_n       (arst_n),
        .cycle_en_i   (state_q != ST_HALT),
        .instret_en_i (pc_en),
        .cycle_cnt_o  (cycle_cnt),
        .instret_cnt_o(instret_cnt)
    );
`endif

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Directed self-checking bench for mc_core_ctrl; runs a RESET_HALT=0 and a RESET_HALT=1 instance side by side.
// With CTRL_PERF_CNT_EN defined it also checks the performance counters.
module tb_mc_core_ctrl;
    import mc_ctrl_pkg::*;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    // Stimulus bits: {imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid, branch_taken, start}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_GI   = 6'b100000;
    localparam logic [5:0] S_RI   = 6'b010000;
    localparam logic [5:0] S_GD   = 6'b001000;
    localparam logic [5:0] S_RD   = 6'b000100;
    localparam logic [5:0] S_TK   = 6'b000010;
    localparam logic [5:0] S_ST   = 6'b000001;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       branch_taken = 1'b0;
    logic       imem_gnt = 1'b0, imem_rvalid = 1'b0, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;

    logic       imemReqA, dmemReqA, dmemWeA, irEnA, pcEnA, aluSrcBA, rfWeA, illegalA, haltedA;
    logic [1:0] pcSelA, wbSelA;
    logic       imemReqB, dmemReqB, dmemWeB, irEnB, pcEnB, aluSrcBB, rfWeB, illegalB, haltedB;
    logic [1:0] pcSelB, wbSelB;
`ifdef CTRL_PERF_CNT_EN
    logic [63:0] cycleCntA, instretCntA, cycleCntB, instretCntB;
`endif

    logic [12:0] vecA, vecB;
    assign vecA = {imemReqA, dmemReqA, dmemWeA, irEnA, pcEnA, pcSelA, aluSrcBA, wbSelA, rfWeA, illegalA, haltedA};
    assign vecB = {imemReqB, dmemReqB, dmemWeB, irEnB, pcEnB, pcSelB, aluSrcBB, wbSelB, rfWeB, illegalB, haltedB};

    int  checkCount = 0;
    int  passCount  = 0;
    logic expIll   = 1'b0;
    logic bothLive = 1'b0;

    mc_core_ctrl #(.RESET_HALT(0)) dutA (
        .clk(clk), .arst_n(arst_n), .start(start), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .imem_req(imemReqA), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .dmem_req(dmemReqA), .dmem_we(dmemWeA),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .ir_en(irEnA), .pc_en(pcEnA),
        .pc_sel(pcSelA), .alu_src_b(aluSrcBA), .wb_sel(wbSelA), .rf_we(rfWeA),
        .illegal(illegalA),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt(cycleCntA), .instret_cnt(instretCntA),
`endif
        .halted(haltedA)
    );

    mc_core_ctrl #(.RESET_HALT(1)) dutB (
        .clk(clk), .arst_n(arst_n), .start(start), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .imem_req(imemReqB), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .dmem_req(dmemReqB), .dmem_we(dmemWeB),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .ir_en(irEnB), .pc_en(pcEnB),
        .pc_sel(pcSelB), .alu_src_b(aluSrcBB), .wb_sel(wbSelB), .rf_we(rfWeB),
        .illegal(illegalB),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt(cycleCntB), .instret_cnt(instretCntB),
`endif
        .halted(haltedB)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [12:0] ev(input logic ireq, input logic dreq, input logic we,
                                       input logic ir, input logic pc, input logic [1:0] psel,
                                       input logic srcb, input logic [1:0] wsel, input logic rf,
                                       input logic hlt);
        return {ireq, dreq, we, ir, pc, psel, srcb, wsel, rf, 1'b0, hlt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] s);
        {imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid, branch_taken, start} = s;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    // One clock cycle: drive, compare both instances (when in lockstep), advance
    task automatic step(input string tag, input logic [5:0] s, input logic [12:0] expv);
        logic [12:0] e;
        applyStimulus(s);
        e = {expv[12:2], expIll, expv[0]};
        checkOutput({tag, ".a"}, 64'(vecA), 64'(e));
        if (bothLive) checkOutput({tag, ".b"}, 64'(vecB), 64'(e));
        tick();
    endtask

    task automatic doFetch(input string tag);
        step({tag, ".fr"}, S_GI, ev(Y,N,N,N,N,2'd0,N,2'd0,N,N));
        step({tag, ".fw"}, S_RI, ev(N,N,N,Y,N,2'd0,N,2'd0,N,N));
    endtask

    task automatic runOp(input string tag);
        opcode = OPC_OP; funct3 = 3'd0;
        doFetch(tag);
        step({tag, ".dec"}, S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step({tag, ".ex"},  S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step({tag, ".wb"},  S_NONE, ev(N,N,N,N,Y,2'd0,N,2'd0,Y,N));
    endtask

    // Bring the RESET_HALT=1 instance out of HALT while the other waits in FETCH_REQ
    task automatic resyncB(input string tag);
        bothLive = 1'b0;
        applyStimulus(S_NONE);
        checkOutput({tag, ".hold.b"}, 64'(vecB), 64'(ev(N,N,N,N,N,2'd0,N,2'd0,N,Y)));
        step({tag, ".start"}, S_ST, ev(Y,N,N,N,N,2'd0,N,2'd0,N,N));
        applyStimulus(S_NONE);
        checkOutput({tag, ".run.b"}, 64'(vecB), 64'(ev(Y,N,N,N,N,2'd0,N,2'd0,N,N)));
        bothLive = 1'b1;
    endtask

    task automatic resetAndRelease(input string tag);
        arst_n = 1'b0;
        expIll = 1'b0;
        bothLive = 1'b0;
        applyStimulus(S_GI);
        checkOutput({tag, ".rst.a"}, 64'(vecA), 64'd0);
        checkOutput({tag, ".rst.b"}, 64'(vecB), 64'd0);
        tick();
        tick();
        checkOutput({tag, ".rstHeld.a"}, 64'(vecA), 64'd0);
        arst_n = 1'b1;
        applyStimulus(S_NONE);
        checkOutput({tag, ".rel.b"}, 64'(vecB), 64'(ev(N,N,N,N,N,2'd0,N,2'd0,N,Y)));
        checkOutput({tag, ".rel.a"}, 64'(vecA), 64'(ev(Y,N,N,N,N,2'd0,N,2'd0,N,N)));
    endtask

    initial begin
        resetAndRelease("init");
        tick();
        resyncB("init");

        // Register-register ALU op, zero-wait memories: 5 cycles
        runOp("op");

        // Branch taken then not taken: 4 cycles each, no register write
        opcode = OPC_BRANCH;
        doFetch("brT");
        step("brT.dec", S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("brT.ex",  S_TK,   ev(N,N,N,N,Y,2'd1,N,2'd0,N,N));
        doFetch("brN");
        step("brN.dec", S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("brN.ex",  S_NONE, ev(N,N,N,N,Y,2'd0,N,2'd0,N,N));

        // Load with gnt 3 cycles late and rvalid 2 cycles late: 12 cycles
        opcode = OPC_LOAD;
        doFetch("ld");
        step("ld.dec", S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("ld.ex",  S_NONE, ev(N,N,N,N,N,2'd0,Y,2'd0,N,N));
        for (int i = 0; i < 3; i++)
            step("ld.mreqWait", S_NONE, ev(N,Y,N,N,N,2'd0,N,2'd0,N,N));
        step("ld.mreqGnt", S_GD, ev(N,Y,N,N,N,2'd0,N,2'd0,N,N));
        for (int i = 0; i < 2; i++)
            step("ld.mwait", S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("ld.rvalid", S_RD,   ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("ld.wb",     S_NONE, ev(N,N,N,N,Y,2'd0,N,2'd1,Y,N));

        // Store with zero-wait memory: 6 cycles
        opcode = OPC_STORE;
        doFetch("st");
        step("st.dec",  S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("st.ex",   S_NONE, ev(N,N,N,N,N,2'd0,Y,2'd0,N,N));
        step("st.mreq", S_GD,   ev(N,Y,Y,N,N,2'd0,N,2'd0,N,N));
        step("st.mwait",S_RD,   ev(N,N,N,N,Y,2'd0,N,2'd0,N,N));

        // JAL and JALR writeback selects
        opcode = OPC_JAL;
        doFetch("jal");
        step("jal.dec", S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("jal.ex",  S_NONE, ev(N,N,N,N,N,2'd0,Y,2'd0,N,N));
        step("jal.wb",  S_NONE, ev(N,N,N,N,Y,2'd1,N,2'd2,Y,N));
        opcode = OPC_JALR;
        doFetch("jalr");
        step("jalr.dec", S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("jalr.ex",  S_NONE, ev(N,N,N,N,N,2'd0,Y,2'd0,N,N));
        step("jalr.wb",  S_NONE, ev(N,N,N,N,Y,2'd2,N,2'd2,Y,N));

        // ECALL halts without flagging illegal
        opcode = OPC_SYSTEM; funct3 = 3'b000;
        doFetch("ecall");
        step("ecall.dec",   S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("ecall.halt",  S_GI,   ev(N,N,N,N,N,2'd0,N,2'd0,N,Y));
        step("ecall.start", S_ST,   ev(N,N,N,N,N,2'd0,N,2'd0,N,Y));

        // Illegal opcode: sticky flag, no fetch until start, flag survives resume
        opcode = 7'b1111111;
        doFetch("ill");
        step("ill.dec", S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        expIll = 1'b1;
        for (int i = 0; i < 3; i++)
            step("ill.halt", S_GI, ev(N,N,N,N,N,2'd0,N,2'd0,N,Y));
        step("ill.start", S_ST, ev(N,N,N,N,N,2'd0,N,2'd0,N,Y));
        runOp("illResume");

        // Reset pulse in MEM_WAIT of a store abandons the instruction
        opcode = OPC_STORE; funct3 = 3'd0;
        doFetch("stRst");
        step("stRst.dec",  S_NONE, ev(N,N,N,N,N,2'd0,N,2'd0,N,N));
        step("stRst.ex",   S_NONE, ev(N,N,N,N,N,2'd0,Y,2'd0,N,N));
        step("stRst.mreq", S_GD,   ev(N,Y,Y,N,N,2'd0,N,2'd0,N,N));
        resetAndRelease("stRst");
        step("stRst.fetch2", S_NONE, ev(Y,N,N,N,N,2'd0,N,2'd0,N,N));
        resyncB("stRst");
        runOp("postRst");

`ifdef CTRL_PERF_CNT_EN
        // Ten back-to-back ALU ops straight out of reset: 50 cycles, 10 retired
        resetAndRelease("perf");
        for (int i = 0; i < 10; i++) runOp("perfOp");
        checkOutput("perf.cycle",   cycleCntA,   64'd50);
        checkOutput("perf.instret", instretCntA, 64'd10);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
